// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Legal funct3 encodings: stores only have signed widths, loads add the unsigned variants.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/my_lsu_if.sv
// Word-wide handshaked data-memory bus between the LSU and memory.
interface my_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: legality/alignment check, store lane
// replication with byte enables, and load byte/half extraction.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic        illegal,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    // Legality and natural-alignment check of the incoming access.
    always_comb begin
        illegal    = !f3_legal(is_store, funct3);
        misaligned = 1'b0;
        case (funct3)
            F3_H, F3_HU: misaligned = addr_lo[0];
            F3_W:        misaligned = (addr_lo != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    end

    // Byte enables and lane-replicated store data; loads read the whole word.
    always_comb begin
        be        = 4'b1111;
        wdata_rep = 32'd0;
        if (is_store) begin
            case (funct3)
                F3_B: begin
                    be        = 4'b0001 << addr_lo;
                    wdata_rep = {4{wdata[7:0]}};
                end
                F3_H: begin
                    be        = 4'b0011 << addr_lo;
                    wdata_rep = {2{wdata[15:0]}};
                end
                F3_W: begin
                    be        = 4'b1111;
                    wdata_rep = wdata;
                end
                default: begin
                    be        = 4'b0000;
                    wdata_rep = 32'd0;
                end
            endcase
        end else begin
            be        = 4'b1111;
            wdata_rep = 32'd0;
        end
    end

    // Pick the addressed byte and half out of the returned word.
    always_comb begin
        ld_byte_s = 8'd0;
        case (ld_off)
            2'd0:    ld_byte_s = ld_word[7:0];
            2'd1:    ld_byte_s = ld_word[15:8];
            2'd2:    ld_byte_s = ld_word[23:16];
            2'd3:    ld_byte_s = ld_word[31:24];
            default: ld_byte_s = 8'd0;
        endcase
        if (ld_off[1]) begin
            ld_half_s = ld_word[31:16];
        end else begin
            ld_half_s = ld_word[15:0];
        end
    end

    // Sign- or zero-extend the selected lane into the write-back value.
    always_comb begin
        ld_data = 32'd0;
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte_s[7]}}, ld_byte_s};
            F3_BU:   ld_data = {24'd0, ld_byte_s};
            F3_H:    ld_data = {{16{ld_half_s[15]}}, ld_half_s};
            F3_HU:   ld_data = {16'd0, ld_half_s};
            F3_W:    ld_data = ld_word;
            default: ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/my_lsu.sv
// Multi-cycle load/store unit: stalls the core while a handshaked
// word-bus access is in flight, with alignment checking and timeout.
module my_lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_error,
    my_lsu_if.master    bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t      state_r;
    lsu_state_t      state_nxt_s;
    logic [31:0]     addr_r;
    logic [1:0]      off_r;
    logic [2:0]      f3_r;
    logic            we_r;
    logic [3:0]      be_r;
    logic [31:0]     wdata_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]     rdata_r;
    logic            err_r;

    logic            req_s;
    logic            illegal_s;
    logic            mis_raw_s;
    logic [3:0]      be_s;
    logic [31:0]     wdata_rep_s;
    logic [31:0]     ld_data_s;
    logic            accept_s;
    logic            timeout_s;
    logic            stall_s;
    logic            mis_s;
    logic            err_s;

    assign req_s = mem_read | mem_write;

    lsu_align u_align (
        .is_store   (mem_write),
        .funct3     (funct3),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .illegal    (illegal_s),
        .misaligned (mis_raw_s),
        .be         (be_s),
        .wdata_rep  (wdata_rep_s),
        .ld_funct3  (f3_r),
        .ld_off     (off_r),
        .ld_word    (bus.rdata),
        .ld_data    (ld_data_s)
    );

    // Next-state and core-facing handshake outputs.
    always_comb begin
        state_nxt_s = state_r;
        stall_s     = 1'b0;
        mis_s       = 1'b0;
        err_s       = 1'b0;
        accept_s    = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    if (illegal_s) begin
                        err_s = 1'b1;
                    end else if (mis_raw_s) begin
                        mis_s = 1'b1;
                    end else begin
                        accept_s    = 1'b1;
                        stall_s     = 1'b1;
                        state_nxt_s = REQ;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                stall_s = 1'b1;
                if (bus.ack) begin
                    state_nxt_s = DONE;
                end else if (cnt_r == CNT_LAST) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            DONE: begin
                // mem_read/mem_write here still belong to the retiring instruction.
                err_s       = err_r;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, access latches, wait counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            addr_r  <= 32'd0;
            off_r   <= 2'd0;
            f3_r    <= 3'd0;
            we_r    <= 1'b0;
            be_r    <= 4'd0;
            wdata_r <= 32'd0;
            cnt_r   <= {CNT_W{1'b0}};
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        addr_r  <= {addr[31:2], 2'b00};
                        off_r   <= addr[1:0];
                        f3_r    <= funct3;
                        we_r    <= mem_write;
                        be_r    <= be_s;
                        wdata_r <= wdata_rep_s;
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                    rdata_r <= 32'd0;
                    err_r   <= 1'b0;
                end
                REQ: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (bus.ack) begin
                        rdata_r <= we_r ? 32'd0 : ld_data_s;
                    end else if (timeout_s) begin
                        rdata_r <= 32'd0;
                        err_r   <= 1'b1;
                    end
                end
                DONE: begin
                    rdata_r <= 32'd0;
                    err_r   <= 1'b0;
                end
                default: begin
                    rdata_r <= 32'd0;
                    err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign stall      = stall_s;
    assign misaligned = mis_s;
    assign bus_error  = err_s;
    assign rdata      = rdata_r;

    assign bus.req    = (state_r == REQ);
    assign bus.we     = we_r;
    assign bus.addr   = addr_r;
    assign bus.be     = be_r;
    assign bus.wdata  = wdata_r;

endmodule

// File: tb/tb_my_lsu.sv
// Self-checking bench for my_lsu against a size/offset arithmetic reference model.
module tb_my_lsu;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misaligned;
    logic        bus_error;

    int n_vec = 0;
    int n_err = 0;

    my_lsu_if bus_if ();

    my_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .stall      (stall),
        .misaligned (misaligned),
        .bus_error  (bus_error),
        .bus        (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          n_stall;
        int          n_req;
        int          first_req;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic [3:0]  bbe;
        logic        bwe;
        logic [31:0] rd;
        logic        err;
        logic        mis0;
        logic        ierr0;
        logic        early_bad;
    } obs_t;

    // ---------------- reference model ----------------
    function automatic logic m_illegal(input logic st, input logic [2:0] f3);
        if (st) return !(f3 inside {3'd0, 3'd1, 3'd2});
        return !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    endfunction

    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic m_misal(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a % 4) % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = m_size(f3);
        if (!st || sz == 4) return 4'd15;
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (m_size(f3) == 1) return (wd % 256) * 32'h01010101;
        if (m_size(f3) == 2) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        int off;
        off = int'(a % 4);
        if (m_size(f3) == 1) begin
            v = (w >> (8 * off)) % 256;
            if (f3 < 3'd4 && v >= 32'd128) v = v - 32'd256;
        end else if (m_size(f3) == 2) begin
            v = (w >> (16 * (off / 2))) % 65536;
            if (f3 < 3'd4 && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // ---------------- stimulus driver ----------------
    // Presents one instruction and acts as the memory; ack_at=0 never acks.
    task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] word,
                              input int ack_at, output obs_t o);
        bit done;
        @(negedge clk);
        mem_read      = !st;
        mem_write     = st;
        funct3        = f3;
        addr          = a;
        wdata         = wd;
        bus_if.ack    = 1'b0;
        bus_if.rdata  = word;
        o.n_stall = 0; o.n_req = 0; o.first_req = -1; o.early_bad = 1'b0;
        o.baddr = 32'd0; o.bwdata = 32'd0; o.bbe = 4'd0; o.bwe = 1'b0;
        o.rd = 32'hDEADBEEF; o.err = 1'b0; o.mis0 = 1'b0; o.ierr0 = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (c == 0) begin
                o.mis0  = misaligned;
                o.ierr0 = bus_error;
            end
            if (bus_if.req) begin
                o.n_req++;
                if (o.n_req == 1) begin
                    o.first_req = c;
                    o.baddr  = bus_if.addr;
                    o.bwdata = bus_if.wdata;
                    o.bbe    = bus_if.be;
                    o.bwe    = bus_if.we;
                end
                bus_if.ack = (o.n_req == ack_at);
            end else begin
                bus_if.ack = 1'b0;
            end
            if (stall) begin
                o.n_stall++;
                if (rdata !== 32'd0) o.early_bad = 1'b1;
            end else begin
                o.rd  = rdata;
                o.err = bus_error;
                done  = 1'b1;
            end
            if (!done) @(negedge clk);
        end
        bus_if.ack = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        bus_if.ack = 1'b0;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
        addr = 32'd0; wdata = 32'd0; bus_if.ack = 1'b0; bus_if.rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if ({stall, misaligned, bus_error, bus_if.req, bus_if.we} !== 5'd0 || rdata !== 32'd0 ||
            bus_if.addr !== 32'd0 || bus_if.be !== 4'd0 || bus_if.wdata !== 32'd0) begin
            n_err++;
            $display("FAIL reset_outputs: stall=%b mis=%b err=%b req=%b we=%b rdata=%h addr=%h be=%b wdata=%h, required all zero",
                     stall, misaligned, bus_error, bus_if.req, bus_if.we, rdata, bus_if.addr, bus_if.be, bus_if.wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_sb();
        obs_t o;
        run_access(1'b1, 3'b000, 32'h1003, 32'h000000A5, 32'd0, 1, o);
        n_vec++;
        if (o.baddr !== 32'h1000 || o.bbe !== 4'b1000 || o.bwdata !== 32'hA5A5A5A5 || o.bwe !== 1'b1) begin
            n_err++;
            $display("FAIL sb_bus: addr=%h be=%b wdata=%h we=%b, required 00001000 1000 a5a5a5a5 1",
                     o.baddr, o.bbe, o.bwdata, o.bwe);
        end
        n_vec++;
        if (o.n_stall !== 2 || o.err !== 1'b0 || o.rd !== 32'd0) begin
            n_err++;
            $display("FAIL sb_stall: stall cycles=%0d err=%b rdata=%h, required 2 0 00000000", o.n_stall, o.err, o.rd);
        end
    endtask

    task automatic test_load_fmt();
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b010};
        logic [31:0] as  [4] = '{32'h1002, 32'h1003, 32'h1002, 32'h1000};
        logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h80FF7F01};
        obs_t o;
        for (int i = 0; i < 4; i++) begin
            run_access(1'b0, f3s[i], as[i], 32'd0, 32'h80FF7F01, 1, o);
            n_vec++;
            if (o.rd !== exp[i] || o.bbe !== 4'b1111 || o.bwe !== 1'b0 || o.baddr !== 32'h1000) begin
                n_err++;
                $display("FAIL load_fmt[%0d]: rdata=%h be=%b we=%b addr=%h, required %h 1111 0 00001000",
                         i, o.rd, o.bbe, o.bwe, o.baddr, exp[i]);
            end
        end
    endtask

    task automatic test_misaligned_illegal();
        obs_t o;
        run_access(1'b0, 3'b010, 32'h1002, 32'd0, 32'd0, 1, o);
        n_vec++;
        if (o.mis0 !== 1'b1 || o.ierr0 !== 1'b0 || o.n_req !== 0 || o.n_stall !== 0) begin
            n_err++;
            $display("FAIL misaligned_lw: mis=%b err=%b req cycles=%0d stall cycles=%0d, required 1 0 0 0",
                     o.mis0, o.ierr0, o.n_req, o.n_stall);
        end
        idle_cycle();
        n_vec++;
        if (misaligned !== 1'b0 || bus_if.req !== 1'b0) begin
            n_err++;
            $display("FAIL misaligned_pulse: mis=%b req=%b next cycle, required 0 0", misaligned, bus_if.req);
        end
        run_access(1'b0, 3'b011, 32'h1000, 32'd0, 32'd0, 1, o);
        n_vec++;
        if (o.ierr0 !== 1'b1 || o.mis0 !== 1'b0 || o.n_req !== 0 || o.n_stall !== 0) begin
            n_err++;
            $display("FAIL illegal_f3: err=%b mis=%b req cycles=%0d stall cycles=%0d, required 1 0 0 0",
                     o.ierr0, o.mis0, o.n_req, o.n_stall);
        end
        run_access(1'b1, 3'b101, 32'h1001, 32'd0, 32'd0, 1, o);
        n_vec++;
        if (o.ierr0 !== 1'b1 || o.mis0 !== 1'b0 || o.n_req !== 0) begin
            n_err++;
            $display("FAIL illegal_priority: err=%b mis=%b req cycles=%0d, required 1 0 0", o.ierr0, o.mis0, o.n_req);
        end
        idle_cycle();
    endtask

    task automatic test_wait_states();
        obs_t o;
        run_access(1'b0, 3'b001, 32'h2002, 32'd0, 32'h1234ABCD, 4, o);
        n_vec++;
        if (o.n_stall !== 5 || o.n_req !== 4 || o.err !== 1'b0 || o.rd !== 32'h00001234 || o.early_bad !== 1'b0) begin
            n_err++;
            $display("FAIL wait3: stall=%0d req=%0d err=%b rdata=%h early=%b, required 5 4 0 00001234 0",
                     o.n_stall, o.n_req, o.err, o.rd, o.early_bad);
        end
        idle_cycle();
        n_vec++;
        if (rdata !== 32'd0) begin
            n_err++;
            $display("FAIL rdata_after_done: rdata=%h, required 00000000", rdata);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_access(1'b0, 3'b010, 32'h3000, 32'd0, 32'hCAFEF00D, 0, o);
        n_vec++;
        if (o.n_req !== TO || o.n_stall !== TO + 1 || o.err !== 1'b1 || o.rd !== 32'd0) begin
            n_err++;
            $display("FAIL timeout: req=%0d stall=%0d err=%b rdata=%h, required %0d %0d 1 00000000",
                     o.n_req, o.n_stall, o.err, o.rd, TO, TO + 1);
        end
        idle_cycle();
        n_vec++;
        if (bus_error !== 1'b0 || stall !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_pulse: err=%b stall=%b next cycle, required 0 0", bus_error, stall);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h4000; bus_if.ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_vec++;
        if (bus_if.req !== 1'b1 || stall !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_pre: req=%b stall=%b in 2nd REQ cycle, required 1 1", bus_if.req, stall);
        end
        rst = 1'b1;
        mem_read = 1'b0;
        @(negedge clk);
        #1;
        n_vec++;
        if (bus_if.req !== 1'b0 || stall !== 1'b0 || rdata !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid: req=%b stall=%b rdata=%h, required 0 0 00000000", bus_if.req, stall, rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        run_access(1'b0, 3'b010, 32'h5000, 32'd0, 32'h11112222, 1, o1);
        run_access(1'b0, 3'b100, 32'h5101, 32'd0, 32'h0000C300, 1, o2);
        n_vec++;
        if (o1.rd !== 32'h11112222 || o2.first_req !== 1 || o2.n_stall !== 2 || o2.rd !== 32'h000000C3) begin
            n_err++;
            $display("FAIL back_to_back: rd1=%h first_req=%0d stall2=%0d rd2=%h, required 11112222 1 2 000000c3",
                     o1.rd, o2.first_req, o2.n_stall, o2.rd);
        end
        idle_cycle();
    endtask

    task automatic test_random();
        obs_t o;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a, wd, w;
        int          ack_at, exp_req, exp_stall;
        logic        exp_err;
        logic [31:0] exp_rd;
        for (int i = 0; i < 80; i++) begin
            st     = 1'($urandom_range(0, 1));
            f3     = 3'($urandom_range(0, 7));
            a      = $urandom;
            wd     = $urandom;
            w      = $urandom;
            ack_at = $urandom_range(0, TO + 1);
            run_access(st, f3, a, wd, w, ack_at, o);
            n_vec++;
            if (m_illegal(st, f3)) begin
                if (o.ierr0 !== 1'b1 || o.mis0 !== 1'b0 || o.n_req !== 0 || o.n_stall !== 0) begin
                    n_err++;
                    $display("FAIL rnd_illegal[%0d]: st=%b f3=%0d err=%b mis=%b req=%0d stall=%0d, required 1 0 0 0",
                             i, st, f3, o.ierr0, o.mis0, o.n_req, o.n_stall);
                end
            end else if (m_misal(f3, a)) begin
                if (o.mis0 !== 1'b1 || o.ierr0 !== 1'b0 || o.n_req !== 0 || o.n_stall !== 0) begin
                    n_err++;
                    $display("FAIL rnd_misal[%0d]: st=%b f3=%0d a=%h mis=%b err=%b req=%0d stall=%0d, required 1 0 0 0",
                             i, st, f3, a, o.mis0, o.ierr0, o.n_req, o.n_stall);
                end
            end else begin
                if (ack_at >= 1 && ack_at <= TO) begin
                    exp_req = ack_at; exp_err = 1'b0;
                    exp_rd  = st ? 32'd0 : m_load(f3, a, w);
                end else begin
                    exp_req = TO; exp_err = 1'b1; exp_rd = 32'd0;
                end
                exp_stall = exp_req + 1;
                if (o.n_req !== exp_req || o.n_stall !== exp_stall || o.err !== exp_err || o.rd !== exp_rd ||
                    o.baddr !== {a[31:2], 2'b00} || o.bbe !== m_be(st, f3, a) || o.bwe !== st ||
                    (st && o.bwdata !== m_wdata(f3, wd)) || o.early_bad !== 1'b0) begin
                    n_err++;
                    $display("FAIL rnd_access[%0d]: st=%b f3=%0d a=%h ack_at=%0d got req=%0d stall=%0d err=%b rd=%h addr=%h be=%b we=%b wd=%h; required %0d %0d %b %h %h %b %b %h",
                             i, st, f3, a, ack_at, o.n_req, o.n_stall, o.err, o.rd, o.baddr, o.bbe, o.bwe, o.bwdata,
                             exp_req, exp_stall, exp_err, exp_rd, {a[31:2], 2'b00}, m_be(st, f3, a), st,
                             st ? m_wdata(f3, wd) : o.bwdata);
                end
            end
            if ($urandom_range(0, 1) == 0) begin
                idle_cycle();
                n_vec++;
                if (stall !== 1'b0 || bus_if.req !== 1'b0) begin
                    n_err++;
                    $display("FAIL rnd_idle[%0d]: stall=%b req=%b, required 0 0", i, stall, bus_if.req);
                end
            end
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_sb();
        test_load_fmt();
        test_misaligned_illegal();
        test_wait_states();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/my_lsu.md
# my_lsu

Multi-cycle load/store unit between the single-cycle datapath's memory port (address = ALU result, store data = rs2, load data back to the write-back mux) and a word-wide, handshaked data-memory bus. Handles byte/halfword lane selection, store byte enables, load sign/zero extension, alignment checking and bus timeout. While an access is in flight it stalls the core, holding the PC and suppressing register write.

## Interface
- `TIMEOUT_CYCLES`, default 16: number of bus-wait cycles, counted in REQ and including the first, before an access is abandoned. Must be ≥ 1.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_read` in 1: the current instruction is a load.
- `mem_write` in 1: the current instruction is a store. Never asserted together with `mem_read`.
- `funct3` in 3: access size and signedness, `inst[14:12]`.
- `addr` in 32: byte address from the ALU.
- `wdata` in 32: store data, i.e. rs2.
- `rdata` out 32: formatted load data. Valid in DONE; 0 otherwise.
- `stall` out 1: hold PC, register file and CSR state this cycle.
- `misaligned` out 1: one-cycle pulse for a misaligned access. No bus access is made.
- `bus_error` out 1: one-cycle pulse for an illegal `funct3` or a timeout.
- `bus_req` out 1: bus request. Held until `bus_ack`.
- `bus_we` out 1: the bus request is a write.
- `bus_addr` out 32: word-aligned address; `[1:0]` are always 0.
- `bus_be` out 4: byte enables. All ones for loads.
- `bus_wdata` out 32: store data replicated across byte lanes.
- `bus_ack` in 1: the bus completes the request this cycle.
- `bus_rdata` in 32: read word. Valid when `bus_ack` is high.

## Operation
- The FSM has three states: IDLE, REQ, DONE. Reset state is IDLE.
- **IDLE**
  - With no request: `stall`=0 and the state stays IDLE.
  - On `mem_read` or `mem_write`, the access is first checked for legality:
    - Illegal `funct3` is 011, 110 or 111 for loads, or anything other than 000/001/010 for stores. Result: `bus_error`=1, `stall`=0, state stays IDLE.
    - Misaligned means LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0. Result: `misaligned`=1, `stall`=0, state stays IDLE.
    - An illegal `funct3` takes priority over misalignment.
  - A legal access:
    - Latch `{addr[31:2],2'b00}`, `addr[1:0]`, `funct3`, direction, byte enables and replicated write data.
    - `stall`=1 combinationally. Next state REQ.
- **REQ**
  - Outputs: `bus_req`=1, `stall`=1; the latched values drive `bus_addr`, `bus_we`, `bus_be` and `bus_wdata`.
  - The wait counter increments each REQ cycle.
  - On `bus_ack`: capture the formatted load data into `rdata` (0 for stores). Next state DONE.
  - Else, when the counter reaches `TIMEOUT_CYCLES`: set a pending error, force `rdata`=0. Next state DONE.
  - `bus_ack` in the same cycle as the timeout wins; no error is raised.
- **DONE**
  - `stall`=0, so the instruction retires on this edge. `bus_error` is asserted here if an error is pending.
  - Next state is always IDLE. DONE never accepts a new request, because `mem_read`/`mem_write` still belong to the retiring instruction.
- **Store lanes**
  - SB: `bus_be` = `4'b0001 << addr[1:0]`; `bus_wdata` = `{4{wdata[7:0]}}`.
  - SH: `bus_be` = `4'b0011 << addr[1:0]`; `bus_wdata` = `{2{wdata[15:0]}}`.
  - SW: `bus_be` = `4'b1111`; `bus_wdata` = `wdata`.
- **Load format**
  - LB/LBU: select byte `addr[1:0]`, then sign- or zero-extend.
  - LH/LHU: select half `addr[1]`, then sign- or zero-extend.
  - LW: pass the word through.
- **Reset**
  - Reset mid-access drops `bus_req` on the next edge and returns to IDLE. The bus access is abandoned with no retry.
  - All outputs are 0 out of reset.

## Timing
- Zero-wait bus (ack in the first REQ cycle): the access takes 3 cycles, with `stall` = 1,1,0.
- With N wait cycles (ack in the (N+1)th REQ cycle): 3+N cycles.
- Timeout: DONE follows the `TIMEOUT_CYCLES`-th REQ cycle, so the access takes `TIMEOUT_CYCLES`+2 cycles.
- `rdata`, `bus_*`, `misaligned` and `bus_error` come straight from registers or latched state, except that the IDLE-cycle `stall`, `misaligned` and `bus_error` are combinational from the inputs.
- Non-memory instructions cost 0 extra cycles.

## Structure
- `lsu_pkg` holds:
  - the state enum `lsu_state_t` (IDLE/REQ/DONE);
  - `funct3` constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
- Sub-module `lsu_align` is purely combinational. It covers:
  - the legality and alignment check;
  - byte-enable and write-data replication;
  - load extraction and extension.
- `my_lsu` contains the FSM, the latches and the timeout counter.

## Test plan
- **SB**: `addr`=0x1003, `wdata`=0x000000A5, ack in the first REQ cycle.
  - Expect `bus_addr`=0x1000, `bus_be`=4'b1000, `bus_wdata`=0xA5A5A5A5, `bus_we`=1.
  - Expect `stall` = 1,1,0.
- **LB/LBU**: `bus_rdata`=0x80FF7F01.
  - LB at offset 2 → 0xFFFFFFFF. LBU at offset 3 → 0x00000080.
  - LH at offset 2 → 0xFFFF80FF. LW → 0x80FF7F01.
- **Misaligned/illegal**:
  - LW at 0x1002 → `misaligned`=1 for one cycle, `bus_req` never rises, `stall`=0.
  - `funct3`=011 load at 0x1000 → `bus_error`=1 only.
- **Wait states**: ack delayed 3 cycles → `stall` high for 5 cycles, low in the 6th; `rdata` valid in DONE only.
- **Timeout**: `TIMEOUT_CYCLES`=4, no ack → `bus_req` high for 4 cycles, then DONE with `bus_error`=1 and `rdata`=0.
  - Also: ack in the 4th REQ cycle → no error.
- **Reset/back-to-back**:
  - `rst` in the second REQ cycle → `bus_req`=0 and `stall`=0 next cycle.
  - Two consecutive loads → the second request enters REQ exactly one cycle after DONE.
